regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug/verification reader for the processor register file, the read-side counterpart to the flip-flop storage that the write path fills.
- On a start pulse, walks every register address through one register-file read port.
- Captures each word and streams it out as (address, data) beats over a valid/ready handshake.
- Used by testbenches and the debug path to dump architectural state after a program run.

Parameters:
- NUM_REGS, 32, number of registers to walk (addresses 0..NUM_REGS-1)
- WIDTH, 32, register data width in bits
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clock clk
- start  input  1  begin a dump; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  single-cycle pulse after the last beat is accepted
- rf_rd_addr  output  ADDR_W  register-file read address (combinational read port)
- rf_rd_data  input  WIDTH  register-file read data, valid in the same cycle as rf_rd_addr
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat when out_valid && out_ready
- out_addr  output  ADDR_W  register number of current beat
- out_data  output  WIDTH  register contents of current beat

Behaviour:
- Reset: state=IDLE; busy=0, done=0, out_valid=0, out_addr=0, out_data=0, rf_rd_addr=0, internal address counter=0.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - start=1 -> counter=first address (0), go READ.
  - start=0 -> stay.
  - rf_rd_addr driven from counter.
- READ (one cycle):
  - rf_rd_addr=counter.
  - At the clock edge: out_data<=rf_rd_data, out_addr<=counter, out_valid<=1, go SEND.
- SEND:
  - out_valid=1; out_addr and out_data held stable until handshake, even if the register file changes meanwhile (snapshot at READ).
  - On out_valid && out_ready:
    - counter==NUM_REGS-1 -> out_valid<=0, go DONE.
    - otherwise -> counter<=counter+1, out_valid<=0, go READ.
- DONE: done=1 for exactly one cycle, then go IDLE; counter returns to 0.
- busy=1 in READ, SEND and DONE; 0 in IDLE.
- Latency and throughput:
  - First beat: out_valid rises 2 cycles after the cycle start is sampled high (IDLE->READ edge, then READ->SEND edge).
  - Full rate with out_ready tied high: 1 beat per 2 cycles, so NUM_REGS beats in 2*NUM_REGS cycles, then done.
- Boundaries:
  - start while busy: ignored, no restart.
  - start held high: a new dump begins only after returning to IDLE; the start level is re-sampled there, so start held high gives back-to-back dumps.
  - out_ready high while out_valid=0: no effect.
  - out_ready low indefinitely: stay in SEND, no data loss, no counter advance.
  - Counter never wraps past NUM_REGS-1; no beat for addresses >= NUM_REGS.
  - Reset mid-dump (any state): next cycle all outputs at reset values, state IDLE; the partial dump is abandoned and done is not asserted.
  - reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: REGFILE_DUMP_SKIP_R0_EN
- Defined:
  - The walk starts at address 1; the hard-wired zero register is never read or emitted.
  - A dump is NUM_REGS-1 beats.
  - Counter reset value and IDLE value become 1.
  - First beat has out_addr=1.
- Undefined: the walk starts at address 0, producing NUM_REGS beats as described above.

Test Plan:
- Register file model preloaded with reg[i]=32'hA000_0000+i, out_ready=1, one-cycle start pulse -> 32 beats (addr i, data 32'hA000_0000+i) in order, out_valid high every other cycle, done pulses once at cycle 65 after start, busy low afterward.
- Same preload, out_ready toggled 0/1 pseudo-randomly -> identical 32-beat sequence; out_addr and out_data never change while out_valid=1 && out_ready=0.
- Backpressure hold: out_ready=0 for 20 cycles on beat 5, register file writes reg[5]=32'hDEAD_BEEF during the stall -> emitted data remains 32'hA000_0005.
- reset asserted in SEND at beat 10 -> next cycle busy=0, out_valid=0, out_addr=0, out_data=0, no done; a new start then yields a full dump beginning at addr 0.
- start re-pulsed during beat 3 -> ignored, exactly 32 beats, single done pulse.
- With REGFILE_DUMP_SKIP_R0_EN defined, same preload -> 31 beats, first beat addr 1 data 32'hA000_0001, last beat addr 31, done once.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: after a start pulse, reads every register through one
// combinational register-file read port and streams it out as (address, data)
// beats on a valid/ready handshake. Each word is captured when it is read, so
// a beat stays unchanged while it waits for ready, even if the register file
// is written meanwhile.
// Optional build macro REGFILE_DUMP_SKIP_R0_EN: the walk starts at address 1
// and never reads or emits the hard-wired zero register.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]  rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [WIDTH-1:0]  out_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

`ifdef REGFILE_DUMP_SKIP_R0_EN
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(0);
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] counter;
  logic              handshake;

  assign handshake  = out_valid && out_ready;
  assign rf_rd_addr = counter;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  // State register; reset abandons any dump in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: one read cycle, then hold in SEND until the beat is taken.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = READ;
      READ: state_next = SEND;
      SEND: if (handshake) state_next = (counter == LAST_ADDR) ? DONE : READ;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address walk and beat snapshot; the counter stops at the last address.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter   <= FIRST_ADDR;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) counter <= FIRST_ADDR;
        READ: begin
          out_data  <= rf_rd_data;
          out_addr  <= counter;
          out_valid <= 1'b1;
        end
        SEND: if (handshake) begin
          out_valid <= 1'b0;
          if (counter != LAST_ADDR) counter <= counter + ADDR_W'(1);
        end
        DONE: counter <= FIRST_ADDR;
        default: counter <= FIRST_ADDR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full-rate dump, random backpressure,
// long stall with a register write during the stall, ignored restart,
// reset in the middle of a dump, and reset/start in the same cycle.
module tb_regfile_dump_reader;

`ifdef REGFILE_DUMP_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NUM = 32 - FIRST;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;

  logic [31:0] rf [32];

  int compareCount  = 0;
  int mismatchCount = 0;

  regfile_dump_reader #(.NUM_REGS(32), .WIDTH(32), .ADDR_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr(out_addr),
    .out_data(out_data)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Combinational register-file read port model.
  assign rf_rd_data = rf[rf_rd_addr];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One dump: 0 = ready tied high, 1 = random ready, 2 = long stall on register 5
  // with a write to register 5 during the stall, 3 = start re-pulsed on beat 3.
  task automatic applyStimulus(input int mode, input string tag);
    int edgeIdx = 0;
    int beatIdx = 0;
    int doneCount = 0;
    int doneEdge = -1;
    int stallCnt = 0;
    bit finished = 1'b0;
    bit restartPulsed = 1'b0;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    while (!finished && edgeIdx < 600) begin
      if (out_valid) begin
        checkOutput({tag, "_addr"}, 64'(out_addr), 64'(beatIdx + FIRST));
        checkOutput({tag, "_data"}, 64'(out_data), 64'(32'hA000_0000 + beatIdx + FIRST));
      end
      if (mode == 0 && edgeIdx < 2 * NUM)
        checkOutput({tag, "_valid_cadence"}, 64'(out_valid), 64'(edgeIdx % 2 == 1));
      if (done) begin
        doneCount++;
        if (doneEdge < 0) doneEdge = edgeIdx;
      end else if (doneCount > 0) begin
        finished = 1'b1;
      end
      if (!finished) begin
        start = 1'b0;
        out_ready = 1'b1;
        if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        if (mode == 2 && out_valid && out_addr == 5'd5 && stallCnt < 20) begin
          out_ready = 1'b0;
          stallCnt++;
          if (stallCnt == 10) rf[5] = 32'hDEAD_BEEF;
        end
        if (mode == 3 && out_valid && out_addr == 5'd3 && !restartPulsed) begin
          start = 1'b1;
          restartPulsed = 1'b1;
        end
        if (out_valid && out_ready) beatIdx++;
        stepCycle();
        edgeIdx++;
      end
    end
    start = 1'b0;
    checkOutput({tag, "_completed"}, 64'(finished), 64'(1));
    checkOutput({tag, "_beats"}, 64'(beatIdx), 64'(NUM));
    checkOutput({tag, "_done_pulses"}, 64'(doneCount), 64'(1));
    if (mode == 0) checkOutput({tag, "_done_edge"}, 64'(doneEdge), 64'(2 * NUM));
    if (mode == 2) checkOutput({tag, "_stall_cycles"}, 64'(stallCnt), 64'(20));
    checkOutput({tag, "_busy_after"}, 64'(busy), 64'(0));
    checkOutput({tag, "_valid_after"}, 64'(out_valid), 64'(0));
  endtask

  // Linear sequence of directed steps.
  initial begin
    int waitCnt;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + i;

    stepCycle();
    stepCycle();
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_addr", 64'(out_addr), 64'(0));
    checkOutput("reset_data", 64'(out_data), 64'(0));
    checkOutput("reset_rd_addr", 64'(rf_rd_addr), 64'(FIRST));
    reset = 1'b0;
    stepCycle();
    checkOutput("idle_busy", 64'(busy), 64'(0));

    applyStimulus(0, "full_rate");
    applyStimulus(1, "random_ready");
    applyStimulus(2, "stall_hold");
    rf[5] = 32'hA000_0005;
    applyStimulus(3, "restart_ignored");

    // Reset while beat 10 is waiting in SEND.
    out_ready = 1'b1;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    waitCnt = 0;
    while (!(out_valid && out_addr == 5'd10) && waitCnt < 100) begin
      stepCycle();
      waitCnt++;
    end
    checkOutput("midreset_reached_beat10", 64'(out_valid && out_addr == 5'd10), 64'(1));
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset_addr", 64'(out_addr), 64'(0));
    checkOutput("midreset_data", 64'(out_data), 64'(0));
    checkOutput("midreset_done", 64'(done), 64'(0));
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("midreset_no_done", 64'(done), 64'(0));
      checkOutput("midreset_idle", 64'(busy), 64'(0));
    end
    applyStimulus(0, "after_reset");

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    stepCycle();
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset_start_busy", 64'(busy), 64'(0));
    stepCycle();
    checkOutput("reset_start_stays_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
